// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the data-side SRAM arbiter.
package sram_arb_pkg;

  localparam logic M_CORE   = 1'b0;
  localparam logic M_BRIDGE = 1'b1;

  // One entry per granted transaction: who issued it and whether it is answered locally.
  typedef struct packed {
    logic err;
    logic id;
  } resp_tag_t;

  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base_addr,
                                         input logic [31:0] end_addr);
    return (addr >= base_addr) && (addr < end_addr);
  endfunction

endpackage

// File: rtl/resp_tag_fifo.sv
// In-order response tag FIFO; head is visible combinationally so responses route in the same cycle.
module resp_tag_fifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push,
  input  resp_tag_t     push_data,
  input  logic          pop,
  output resp_tag_t     head,
  output logic [CW-1:0] count,
  output logic          full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_tag_t       mem_reg [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign count   = count_reg;
  assign head    = mem_reg[rd_ptr_reg];
  assign do_push = push && !full;
  assign do_pop  = pop && (count_reg != '0);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/sram_d_arbiter.sv
// Two-master round-robin OBI arbiter for the SRAM data port; out-of-window accesses
// are answered locally with an error response.
module sram_d_arbiter
  import sram_arb_pkg::*;
#(
  parameter logic [31:0] SRAM_BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] SRAM_END_ADDR  = 32'h8000_C000,
  parameter int          FIFO_DEPTH     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        s_req_o,
  input  logic        s_gnt_i,
  output logic [31:0] s_addr_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i,
  output logic        illegal_access_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          last_grant_reg;
  logic          lock_reg;
  logic          lock_sel_reg;
  logic          illegal_reg;
  logic          sel;
  logic          sel_req;
  logic [31:0]   sel_addr;
  logic          in_range;
  logic          full;
  logic          grant;
  logic          pop;
  logic [CW-1:0] count;
  resp_tag_t     head;
  resp_tag_t     push_tag;

  // A stalled master keeps the selection until granted so its request stays stable.
  always_comb begin
    if (lock_reg)                   sel = lock_sel_reg;
    else if (m0_req_i && m1_req_i)  sel = ~last_grant_reg;
    else if (m1_req_i)              sel = M_BRIDGE;
    else                            sel = M_CORE;
  end

  assign sel_req  = (sel == M_BRIDGE) ? m1_req_i : m0_req_i;
  assign sel_addr = (sel == M_BRIDGE) ? m1_addr_i : m0_addr_i;
  assign in_range = addr_in_range(sel_addr, SRAM_BASE_ADDR, SRAM_END_ADDR);
  assign grant    = sel_req && !full && (in_range ? s_gnt_i : 1'b1);

  assign s_req_o   = sel_req && in_range && !full;
  assign s_addr_o  = sel_req ? sel_addr : '0;
  assign s_we_o    = sel_req && ((sel == M_BRIDGE) ? m1_we_i : m0_we_i);
  assign s_be_o    = sel_req ? ((sel == M_BRIDGE) ? m1_be_i : m0_be_i) : '0;
  assign s_wdata_o = sel_req ? ((sel == M_BRIDGE) ? m1_wdata_i : m0_wdata_i) : '0;

  assign m0_gnt_o = grant && (sel == M_CORE);
  assign m1_gnt_o = grant && (sel == M_BRIDGE);

  assign push_tag = '{err: !in_range, id: sel};

  resp_tag_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (grant),
    .push_data (push_tag),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full)
  );

  // Local errors retire immediately; slave rvalid is ignored while such an entry is at the head.
  assign pop = (count != '0) && (head.err || s_rvalid_i);

  assign m0_rvalid_o = pop && (head.id == M_CORE);
  assign m1_rvalid_o = pop && (head.id == M_BRIDGE);
  assign m0_err_o    = m0_rvalid_o && head.err;
  assign m1_err_o    = m1_rvalid_o && head.err;
  assign m0_rdata_o  = (m0_rvalid_o && !head.err) ? s_rdata_i : '0;
  assign m1_rdata_o  = (m1_rvalid_o && !head.err) ? s_rdata_i : '0;

  assign illegal_access_o = illegal_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_reg <= M_BRIDGE;
      lock_reg       <= 1'b0;
      lock_sel_reg   <= M_CORE;
      illegal_reg    <= 1'b0;
    end else begin
      illegal_reg <= grant && !in_range;
      if (grant) begin
        last_grant_reg <= sel;
        lock_reg       <= 1'b0;
      end else if (sel_req) begin
        lock_reg     <= 1'b1;
        lock_sel_reg <= sel;
      end else begin
        lock_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_d_arbiter.sv
// Directed bench for sram_d_arbiter with a behavioural SRAM and an in-order response scoreboard.
module tb_sram_d_arbiter;

  typedef struct {
    logic        id;
    logic        err;
    logic [31:0] data;
  } exp_t;

  localparam logic [31:0] A0 = 32'h8000_0100;
  localparam logic [31:0] A1 = 32'h8000_0200;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o, m0_err_o;
  logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
  logic [3:0]  m0_be_i;
  logic        m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o, m1_err_o;
  logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
  logic [3:0]  m1_be_i;
  logic        s_req_o, s_gnt_i, s_we_o, s_rvalid_i;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic [3:0]  s_be_o;
  logic        illegal_access_o;

  int          errors = 0;
  int          checks = 0;
  exp_t        sb[$];
  logic [31:0] pending[$];
  logic        rvalid_en;

  always #5 clk = ~clk;

  sram_d_arbiter dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o),
    .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o),
    .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
    .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .illegal_access_o(illegal_access_o)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h8000_0010) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic in_win(input logic [31:0] a);
    return (a >= 32'h8000_0000) && (a < 32'h8000_C000);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic id, input logic [31:0] a);
    exp_t e;
    e.id   = id;
    e.err  = !in_win(a);
    e.data = e.err ? 32'h0 : mem_val(a);
    sb.push_back(e);
  endtask

  // One cycle of master/slave-grant stimulus plus the expected combinational response.
  task automatic step(input string tag, input logic r0, input logic [31:0] a0,
                      input logic r1, input logic [31:0] a1, input logic sg,
                      input logic eg0, input logic eg1, input logic esreq,
                      input logic [31:0] ea, input logic eill);
    @(negedge clk);
    m0_req_i = r0; m0_addr_i = a0;
    m1_req_i = r1; m1_addr_i = a1;
    s_gnt_i  = sg;
    #1;
    check({tag, ".m0_gnt"}, 32'(m0_gnt_o), 32'(eg0));
    check({tag, ".m1_gnt"}, 32'(m1_gnt_o), 32'(eg1));
    check({tag, ".s_req"},  32'(s_req_o),  32'(esreq));
    check({tag, ".illegal"}, 32'(illegal_access_o), 32'(eill));
    if (esreq) check({tag, ".s_addr"}, s_addr_o, ea);
    if (eg0) push_exp(1'b0, a0);
    if (eg1) push_exp(1'b1, a1);
    $display("step %-12s m0_req=%b m1_req=%b s_gnt=%b -> m0_gnt=%b m1_gnt=%b s_req=%b ill=%b",
             tag, r0, r1, sg, m0_gnt_o, m1_gnt_o, s_req_o, illegal_access_o);
  endtask

  task automatic idle(input string tag, input logic eill);
    step(tag, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, eill);
  endtask

  // Behavioural SRAM: accepts on req&&gnt, answers in order the cycle after, stallable.
  initial begin
    logic        acc;
    logic [31:0] acc_addr;
    s_rvalid_i = 1'b0;
    s_rdata_i  = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      acc      = s_req_o && s_gnt_i;
      acc_addr = s_addr_o;
      @(posedge clk);
      #1;
      if (acc) pending.push_back(mem_val(acc_addr));
      if (rvalid_en && pending.size() > 0) begin
        s_rvalid_i = 1'b1;
        s_rdata_i  = pending.pop_front();
      end else begin
        s_rvalid_i = 1'b0;
        s_rdata_i  = 32'h0;
      end
    end
  end

  // Response monitor: every master response is matched against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!m0_rvalid_o) begin
        check("m0_idle_err", 32'(m0_err_o), 32'h0);
        check("m0_idle_rdata", m0_rdata_o, 32'h0);
      end
      if (!m1_rvalid_o) begin
        check("m1_idle_err", 32'(m1_err_o), 32'h0);
        check("m1_idle_rdata", m1_rdata_o, 32'h0);
      end
      if (m0_rvalid_o || m1_rvalid_o) begin
        if (sb.size() == 0) begin
          check("unexpected_rvalid", 32'({m1_rvalid_o, m0_rvalid_o}), 32'h0);
        end else begin
          e = sb.pop_front();
          check("resp_master", 32'({m1_rvalid_o, m0_rvalid_o}), e.id ? 32'h2 : 32'h1);
          check("resp_err", 32'(e.id ? m1_err_o : m0_err_o), 32'(e.err));
          check("resp_rdata", e.id ? m1_rdata_o : m0_rdata_o, e.data);
          $display("resp m%0d err=%b rdata=%h (expected err=%b rdata=%h)",
                   e.id, e.id ? m1_err_o : m0_err_o, e.id ? m1_rdata_o : m0_rdata_o,
                   e.err, e.data);
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1; rvalid_en = 1'b1;
    m0_req_i = 1'b0; m0_addr_i = 32'h0; m0_we_i = 1'b0; m0_be_i = 4'hF; m0_wdata_i = 32'h0;
    m1_req_i = 1'b0; m1_addr_i = 32'h0; m1_we_i = 1'b1; m1_be_i = 4'hF; m1_wdata_i = 32'hCAFE_0001;
    s_gnt_i = 1'b0;

    idle("reset0", 1'b0);
    idle("reset1", 1'b0);
    rst_i = 1'b0;

    // Continuous contention from reset alternates M0, M1, ...
    for (int i = 0; i < 4; i++)
      step("alt", 1'b1, A0, 1'b1, A1, 1'b1, (i % 2) == 0, (i % 2) == 1, 1'b1,
           ((i % 2) == 0) ? A0 : A1, 1'b0);
    idle("drain_alt", 1'b0);

    step("rd_beef", 1'b1, 32'h8000_0010, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0010, 1'b0);
    idle("drain_rd", 1'b0);

    // Window end is exclusive: local error, one-cycle illegal pulse.
    step("err_end", 1'b0, 32'h0, 1'b1, 32'h8000_C000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    idle("ill_hi", 1'b1);
    idle("ill_lo", 1'b0);

    step("top_word", 1'b1, 32'h8000_BFFC, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_BFFC, 1'b0);
    step("below", 1'b1, 32'h7FFF_FFFC, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    idle("ill_below", 1'b1);
    idle("ill_below_lo", 1'b0);

    // Lock: M0 stalled by the slave keeps the selection although M1 would win the round.
    step("lock0", 1'b1, A0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, A0, 1'b0);
    step("lock1", 1'b1, A0, 1'b1, A1, 1'b0, 1'b0, 1'b0, 1'b1, A0, 1'b0);
    step("lock2", 1'b1, A0, 1'b1, A1, 1'b0, 1'b0, 1'b0, 1'b1, A0, 1'b0);
    step("lock_gnt", 1'b1, A0, 1'b1, A1, 1'b1, 1'b1, 1'b0, 1'b1, A0, 1'b0);
    step("m1_after", 1'b0, 32'h0, 1'b1, A1, 1'b1, 1'b0, 1'b1, 1'b1, A1, 1'b0);
    idle("drain_lock", 1'b0);

    // Full FIFO blocks the third request until the first response retires.
    rvalid_en = 1'b0;
    step("full1", 1'b1, A0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, A0, 1'b0);
    step("full2", 1'b1, A0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, A0, 1'b0);
    step("full3", 1'b1, A0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    rvalid_en = 1'b1;
    step("full4", 1'b1, A0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step("full5", 1'b1, A0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, A0, 1'b0);
    idle("drain_f0", 1'b0);
    idle("drain_f1", 1'b0);
    idle("drain_f2", 1'b0);

    // Reset with two outstanding; late slave responses must be dropped.
    rvalid_en = 1'b0;
    step("pre_rst0", 1'b1, A0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, A0, 1'b0);
    step("pre_rst1", 1'b0, 32'h0, 1'b1, A1, 1'b1, 1'b0, 1'b1, 1'b1, A1, 1'b0);
    idle("hold", 1'b0);
    rst_i = 1'b1;
    rvalid_en = 1'b1;
    sb.delete();
    idle("in_rst", 1'b0);
    rst_i = 1'b0;
    idle("post_rst0", 1'b0);
    idle("post_rst1", 1'b0);
    step("rst_m0", 1'b1, A0, 1'b1, A1, 1'b1, 1'b1, 1'b0, 1'b1, A0, 1'b0);
    step("rst_m1", 1'b1, A0, 1'b1, A1, 1'b1, 1'b0, 1'b1, 1'b1, A1, 1'b0);
    idle("drain_e0", 1'b0);
    idle("drain_e1", 1'b0);
    idle("drain_e2", 1'b0);

    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
